// File: rtl/ht_walk.sv
// Hashed page-table walker: hashes VPN^ASID to a PTG bucket, fetches PTGs and linearly probes for a hit.
// Optional HT_LAST_HIT_EN: one-entry last-hit register that short-circuits repeat lookups.
package ht_walk_pkg;
  typedef struct packed {
    logic        v;
    logic [13:0] vpn;
    logic [9:0]  asid;
    logic [38:0] ppn;
  } pte_t;

  typedef struct packed {
    pte_t [7:0] ptge;
  } ptg_t;
endpackage

module ht_walk
  import ht_walk_pkg::*;
#(
  parameter int HBITS      = 10,
  parameter int MAX_PROBES = 4,
  parameter int PTG_SHIFT  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] vadr,
  input  logic [9:0]  asid,
  input  logic [31:0] ptbr,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [2:0]  which,
  output ptg_t        rec,
  output logic        mreq,
  output logic [31:0] madr,
  input  logic        mack,
  input  logic        mrdy,
  input  ptg_t        mdat
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CMP, S_DONE} state_t;

  localparam logic [3:0] LP_MAX = 4'(MAX_PROBES);

  state_t           r_state, w_next;
  logic [HBITS-1:0] r_idx;
  logic [3:0]       r_cnt;
  logic [13:0]      r_vpn;
  logic [9:0]       r_asid;
  logic [31:0]      r_base;
  logic             r_found;
  logic [2:0]       r_which;
  ptg_t             r_rec;

  logic [HBITS-1:0] w_idx0;
  logic [31:0]      w_base;
  logic             w_hit;
  logic [2:0]       w_hidx;
  logic             w_lh_match;
  ptg_t             w_lh_rec;
  logic [2:0]       w_lh_which;
  logic             w_unused;

  assign w_idx0   = vadr[18+HBITS-1:18] ^ HBITS'(asid);
  assign w_base   = {ptbr[31:PTG_SHIFT], {PTG_SHIFT{1'b0}}};
  assign w_unused = ^{vadr[17:0], ptbr[PTG_SHIFT-1:0]};

  assign busy  = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_CMP);
  assign done  = (r_state == S_DONE);
  assign mreq  = (r_state == S_REQ);
  assign madr  = r_base + (32'(r_idx) << PTG_SHIFT);
  assign found = r_found;
  assign which = r_which;
  assign rec   = r_rec;

  // Descending scan so the lowest matching PTE index wins.
  always_comb begin
    w_hit  = 1'b0;
    w_hidx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_rec.ptge[i].v && r_rec.ptge[i].vpn == r_vpn && r_rec.ptge[i].asid == r_asid) begin
        w_hit  = 1'b1;
        w_hidx = 3'(i);
      end
    end
  end

`ifdef HT_LAST_HIT_EN
  logic        r_lh_v;
  logic [13:0] r_lh_vpn;
  logic [9:0]  r_lh_asid;
  logic [31:0] r_lh_base;
  ptg_t        r_lh_rec;
  logic [2:0]  r_lh_which;

  assign w_lh_match = r_lh_v && (r_lh_vpn == vadr[31:18]) && (r_lh_asid == asid) &&
                      (r_lh_base == w_base);
  assign w_lh_rec   = r_lh_rec;
  assign w_lh_which = r_lh_which;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lh_v     <= 1'b0;
      r_lh_vpn   <= '0;
      r_lh_asid  <= '0;
      r_lh_base  <= '0;
      r_lh_rec   <= '0;
      r_lh_which <= '0;
    end else if (r_state == S_CMP && w_hit) begin
      r_lh_v     <= 1'b1;
      r_lh_vpn   <= r_vpn;
      r_lh_asid  <= r_asid;
      r_lh_base  <= r_base;
      r_lh_rec   <= r_rec;
      r_lh_which <= w_hidx;
    end
  end
`else
  assign w_lh_match = 1'b0;
  assign w_lh_rec   = '0;
  assign w_lh_which = 3'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req) w_next = w_lh_match ? S_DONE : S_REQ;
      S_REQ:  if (mack) w_next = S_WAIT;
      S_WAIT: if (mrdy) w_next = S_CMP;
      S_CMP:  w_next = (!w_hit && r_cnt < LP_MAX) ? S_REQ : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_vpn   <= '0;
      r_asid  <= '0;
      r_base  <= '0;
      r_found <= 1'b0;
      r_which <= '0;
      r_rec   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req) begin
          r_vpn   <= vadr[31:18];
          r_asid  <= asid;
          r_base  <= w_base;
          r_idx   <= w_idx0;
          r_cnt   <= 4'd1;
          r_found <= w_lh_match;
          r_which <= w_lh_which;
          if (w_lh_match) r_rec <= w_lh_rec;
        end
        S_WAIT: if (mrdy) r_rec <= mdat;
        S_CMP: begin
          if (w_hit) begin
            r_found <= 1'b1;
            r_which <= w_hidx;
          end else if (r_cnt < LP_MAX) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_found <= 1'b0;
            r_which <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ht_walk.sv
// Directed bench for ht_walk: reactive zero-wait memory, hand-computed addresses, latencies and results.
module tb_ht_walk;
  import ht_walk_pkg::*;

  logic        clk = 1'b0;
  logic        rst, req, mack, mrdy;
  logic [31:0] vadr, ptbr, madr;
  logic [9:0]  asid;
  logic        busy, done, found, mreq;
  logic [2:0]  which;
  ptg_t        rec, mdat;

  ht_walk dut (
    .clk(clk), .rst(rst), .req(req), .vadr(vadr), .asid(asid), .ptbr(ptbr),
    .busy(busy), .done(done), .found(found), .which(which), .rec(rec),
    .mreq(mreq), .madr(madr), .mack(mack), .mrdy(mrdy), .mdat(mdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0, bad = 0;
  int          nreq;
  bit          mem_on;
  ptg_t        mem_ptg [4];
  logic [31:0] madr_log [4];
  int          lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic pte_t mk(input logic v, input logic [13:0] vpn, input logic [9:0] as,
                              input logic [38:0] ppn);
    return '{v: v, vpn: vpn, asid: as, ppn: ppn};
  endfunction

  task automatic clr_mem();
    for (int k = 0; k < 4; k++) begin
      mem_ptg[k]         = '0;
      mem_ptg[k].ptge[1] = mk(1'b0, 14'd0, 10'd0, 39'(32'h100 + k));
      madr_log[k]        = '0;
    end
  endtask

  // mack in the same cycle as mreq, mrdy the following cycle
  initial begin
    mack = 1'b0; mrdy = 1'b0; mdat = '0;
    forever begin
      @(negedge clk);
      if (mrdy) mrdy = 1'b0;
      if (mack) begin
        mack = 1'b0;
        mrdy = 1'b1;
        mdat = mem_ptg[(nreq - 1) & 3];
      end else if (mreq && mem_on) begin
        if (nreq < 4) madr_log[nreq] = madr;
        nreq++;
        mack = 1'b1;
      end
    end
  end

  task automatic look(input string tag, input logic [31:0] va, input logic [9:0] as,
                      input logic [31:0] pb, output int l);
    int  t0;
    bit  got;
    @(negedge clk);
    nreq = 0;
    vadr = va; asid = as; ptbr = pb; req = 1'b1;
    t0 = cyc; got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      req = 1'b0;
      if (done) got = 1;
    end
    l = cyc - t0;
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int ndone;
    rst = 1'b0; req = 1'b0; vadr = '0; asid = '0; ptbr = '0;
    mem_on = 1'b1; nreq = 0;
    clr_mem();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_found", 32'(found), 0);
    chk("rst_mreq", 32'(mreq), 0);
    chk("rst_which", 32'(which), 0);
    chk("rst_madr", madr, 0);
    chk("rst_rec", rec.ptge[1].ppn[31:0], 0);
    rst = 1'b1;

    // reset in the middle of a walk, memory holding off mack
    mem_on = 1'b0;
    @(negedge clk);
    vadr = 32'h0004_0000; asid = 10'd0; ptbr = 32'h0010_0000; req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_mreq", 32'(mreq), 1);
    chk("mid_madr", madr, 32'h0010_0080);
    #2 rst = 1'b0;
    #1;
    chk("mid_mreq_drop", 32'(mreq), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_madr0", madr, 0);
    @(negedge clk); rst = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mid_no_done", 32'(ndone), 0);
    mem_on = 1'b1;

    // first-probe hit
    clr_mem();
    mem_ptg[0].ptge[5] = mk(1'b1, 14'd1, 10'd0, 39'h0A5);
    look("hit1", 32'h0004_0000, 10'd0, 32'h0010_0000, lat);
    chk("hit1_lat", 32'(lat), 4);
    chk("hit1_found", 32'(found), 1);
    chk("hit1_which", 32'(which), 5);
    chk("hit1_madr", madr_log[0], 32'h0010_0080);
    chk("hit1_nreq", 32'(nreq), 1);
    chk("hit1_rec", rec.ptge[5].ppn[31:0], 32'h0A5);
    repeat (3) @(negedge clk);
    chk("hit1_hold_found", 32'(found), 1);
    chk("hit1_hold_which", 32'(which), 5);

    // repeat of the same request
    look("rep", 32'h0004_0000, 10'd0, 32'h0010_0000, lat);
`ifdef HT_LAST_HIT_EN
    chk("rep_lat", 32'(lat), 1);
    chk("rep_nreq", 32'(nreq), 0);
`else
    chk("rep_lat", 32'(lat), 4);
    chk("rep_nreq", 32'(nreq), 1);
`endif
    chk("rep_found", 32'(found), 1);
    chk("rep_which", 32'(which), 5);
    chk("rep_rec", rec.ptge[5].ppn[31:0], 32'h0A5);

    // same VPN with asid=1: idx0=0, full walk, all miss
    clr_mem();
    mem_ptg[0].ptge[5] = mk(1'b1, 14'd1, 10'd0, 39'h0A5);
    look("asid1", 32'h0004_0000, 10'd1, 32'h0010_0000, lat);
    chk("asid1_lat", 32'(lat), 13);
    chk("asid1_nreq", 32'(nreq), 4);
    chk("asid1_found", 32'(found), 0);
    chk("asid1_madr0", madr_log[0], 32'h0010_0000);

    // duplicate match: VPN=2, asid=3 -> idx0=1; lowest index wins
    clr_mem();
    mem_ptg[0].ptge[0] = mk(1'b1, 14'd2, 10'd4, 39'h0E0);
    mem_ptg[0].ptge[2] = mk(1'b1, 14'd2, 10'd3, 39'h0E2);
    mem_ptg[0].ptge[6] = mk(1'b1, 14'd2, 10'd3, 39'h0E6);
    look("dup", 32'h0008_0000, 10'd3, 32'h0010_0000, lat);
    chk("dup_found", 32'(found), 1);
    chk("dup_which", 32'(which), 2);
    chk("dup_madr", madr_log[0], 32'h0010_0080);

    // wrap: idx0=0x3FF, hit in third bucket; ptbr low bits ignored
    clr_mem();
    mem_ptg[2].ptge[7] = mk(1'b1, 14'h03FF, 10'd0, 39'h0C7);
    look("wrap", 32'h0FFC_0000, 10'd0, 32'h0010_0055, lat);
    chk("wrap_madr0", madr_log[0], 32'h0011_FF80);
    chk("wrap_madr1", madr_log[1], 32'h0010_0000);
    chk("wrap_madr2", madr_log[2], 32'h0010_0080);
    chk("wrap_nreq", 32'(nreq), 3);
    chk("wrap_lat", 32'(lat), 10);
    chk("wrap_found", 32'(found), 1);
    chk("wrap_which", 32'(which), 7);
    chk("wrap_rec", rec.ptge[7].ppn[31:0], 32'h0C7);

    // exhaustion: VPN=3, asid=5 -> idx0=6, v=0 near-match must not hit
    clr_mem();
    mem_ptg[0].ptge[0] = mk(1'b0, 14'd3, 10'd5, 39'h0D0);
    mem_ptg[1].ptge[3] = mk(1'b1, 14'd4, 10'd5, 39'h0D1);
    mem_ptg[2].ptge[4] = mk(1'b1, 14'd3, 10'd6, 39'h0D2);
    look("miss", 32'h000C_0000, 10'd5, 32'h0010_0000, lat);
    chk("miss_nreq", 32'(nreq), 4);
    chk("miss_found", 32'(found), 0);
    chk("miss_which", 32'(which), 0);
    chk("miss_lat", 32'(lat), 13);
    chk("miss_madr0", madr_log[0], 32'h0010_0300);
    chk("miss_madr3", madr_log[3], 32'h0010_0480);
    chk("miss_rec", rec.ptge[1].ppn[31:0], 32'h103);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ht_walk.md
Name: ht_walk

Overview:
- Hashed page-table lookup engine that sits directly upstream of the physical-address former.
- Takes a virtual address and ASID, hashes the VPN to a page-table-group (PTG) bucket, and fetches the PTG from memory over a req/ack read port.
- Compares the eight PTEs in the PTG and linearly probes further buckets until it gets a hit or runs out of probes.
- Produces found / which / rec, which the address-former stage consumes.

Parameters:
- HBITS, 10, hash index width (buckets = 2^HBITS).
- MAX_PROBES, 4, maximum buckets examined per lookup (1..15).
- PTG_SHIFT, 7, log2 of PTG size in bytes (128-byte PTG).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  lookup request; sampled only in IDLE.
- vadr  in  32  virtual address; VPN = vadr[31:18].
- asid  in  10  address-space id.
- ptbr  in  32  page-table base; bits [PTG_SHIFT-1:0] ignored.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse, result valid.
- found  out  1  hit flag, valid with done, held until next accept.
- which  out  3  index of matching PTE within rec.
- rec  out  ptg_t  PTG containing the hit (last fetched PTG on miss).
- mreq  out  1  memory read request.
- madr  out  32  memory read address.
- mack  in  1  memory accepts request.
- mrdy  in  1  read data valid.
- mdat  in  ptg_t  read data.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, found, mreq = 0; which = 0; madr = 0; rec = all zeros.
- Hash: idx0 = vadr[18+HBITS-1:18] ^ asid[HBITS-1:0]. If HBITS>10, asid is zero-extended. Widths are truncated to HBITS.
- Probe address: madr = {ptbr[31:PTG_SHIFT], PTG_SHIFT'b0} + (idx << PTG_SHIFT), mod 2^32. idx wraps mod 2^HBITS (idx = 2^HBITS-1, +1 -> 0).
- IDLE:
  - On req=1, latch vadr/asid/ptbr, set idx = idx0, probe count = 1, busy = 1 -> REQ.
  - req while busy is ignored; the requester must hold off until done.
- REQ:
  - mreq = 1, madr held stable.
  - On mack=1, mreq drops next cycle -> WAIT.
  - mreq stays high indefinitely without mack.
- WAIT: on mrdy=1, capture mdat into rec -> CMP.
- CMP (one cycle):
  - PTE i hits when ptge[i].v = 1, ptge[i].vpn = latched VPN, and ptge[i].asid = latched asid.
  - Lowest i wins → found = 1, which = i -> DONE.
  - No hit and probe count < MAX_PROBES: idx += 1, count += 1 -> REQ.
  - Otherwise found = 0, which = 0 -> DONE.
- DONE: done = 1 for exactly one cycle, busy = 0 -> IDLE.
- Latency with zero-wait memory (mack same cycle as mreq, mrdy the next cycle): req at cycle 0 -> done at cycle 4 for a first-probe hit; each extra probe adds 3 cycles.
- found, which, rec keep their values after done until the next accept.
- A new req is accepted the cycle after done.
- mrdy outside WAIT and mack outside REQ are ignored.
- Reset mid-walk: abandons the walk immediately, no done pulse, mreq drops asynchronously.

Optional Feature:
- HT_LAST_HIT_EN defined:
  - A one-entry register holds {valid, vpn, asid, ptbr, rec, which} of the last hit.
  - A req matching vpn, asid and ptbr skips memory: IDLE -> DONE with found = 1 and the stored rec/which, so done arrives 1 cycle after req and mreq never asserts.
  - The entry is loaded on every hit and cleared on reset.
- Not defined: every lookup walks memory.

Test Plan:
- Reset then idle: rst=0 during a walk (mreq=1) -> mreq=0 immediately; all outputs 0; no done pulse after release.
- First-probe hit: vadr=0x0004_0000 (VPN=1), asid=0, ptbr=0x0010_0000 -> madr=0x0010_0080; return PTG with ptge[5] = {v=1, vpn=1, asid=0} -> done at cycle 4, found=1, which=5.
- Duplicate match: ptge[2] and ptge[6] both match -> which=2.
- Linear probe with wrap: idx0=0x3FF, misses in buckets 0x3FF and 0x000, hit in bucket 0x001 -> madr sequence 0x0011_FF80, 0x0010_0000, 0x0010_0080; found=1.
- Miss on exhaustion: 4 PTGs with no valid match (including a v=0 entry that would otherwise match) -> exactly 4 mreq handshakes, found=0, which=0.
- HT_LAST_HIT_EN: repeat the first-probe-hit request -> done 1 cycle after req, mreq stays 0, which=5; same request with asid=1 -> full walk.
